multiword_add_seq: RTL
======================

Name: multiword_add_seq

Overview:
- Multi-cycle wide-operand adder sequencer. It sits directly upstream of, and around, the team's 16-bit carry-lookahead adder slice (CLA_16).
- It accepts NUM_WORDS*WORD_W-bit operands through a valid/ready handshake.
- It feeds them word by word, LSW first, into the external combinational adder, chaining the carry between words.
- It returns the full-width sum, carry-out and signed-overflow flag through a second valid/ready handshake.

Parameters:
- WORD_W, 16, width of one adder slice; must match the attached adder.
- NUM_WORDS, 4, number of slices per operation (total width W = WORD_W*NUM_WORDS); must be >= 2.

Ports:
- clk_in  input  1  single clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- in_valid_in  input  1  operand bundle valid.
- in_ready_out  output  1  block can accept an operand bundle.
- a_in  input  W  operand A.
- b_in  input  W  operand B.
- c_in  input  1  carry-in of the whole operation.
- out_valid_out  output  1  result valid.
- out_ready_in  input  1  consumer accepts the result.
- sum_out  output  W  full-width sum.
- c_out  output  1  final carry-out.
- ovf_out  output  1  two's-complement signed overflow.
- add_a_out  output  WORD_W  to adder A_in.
- add_b_out  output  WORD_W  to adder B_in.
- add_c_out  output  1  to adder C_in.
- add_s_in  input  WORD_W  from adder S_out (combinational in the same cycle).
- add_c_in  input  1  from adder C_out.

Behaviour:
- Reset:
  - Asserting rst_n_in low forces state IDLE, in_ready_out=1, out_valid_out=0.
  - sum_out, c_out, ovf_out, word index, carry register and operand registers all go to 0.
  - Reset takes effect immediately (asynchronous) and aborts any operation in progress; no partial result is ever presented.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready_out=1.
  - On in_valid_in & in_ready_out at edge T: capture a_in, b_in; carry_q<=c_in; idx<=0; go to RUN.
- RUN:
  - in_ready_out=0.
  - Combinationally drive add_a_out=A[idx], add_b_out=B[idx], add_c_out=carry_q.
  - Each edge: sum slice idx<=add_s_in; carry_q<=add_c_in; idx<=idx+1.
  - At idx==NUM_WORDS-1: capture the slice, then c_out<=add_c_in and ovf_out<=(A msb==B msb) & (add_s_in msb != A msb), and go to DONE.
  - Word k is captured at edge T+1+k.
- DONE:
  - out_valid_out=1 from edge T+NUM_WORDS onward, so latency is NUM_WORDS cycles from accept to valid.
  - sum_out, c_out and ovf_out are held stable while out_valid_out=1 and out_ready_in=0.
  - in_ready_out=0, so in_valid_in is ignored.
  - On out_valid_out & out_ready_in: return to IDLE and clear out_valid_out. Result registers keep their value until the next operation overwrites them.
- Throughput: one operation per NUM_WORDS+2 cycles minimum. The block does not accept a new bundle in the same cycle a result is consumed.
- Adder drive outside RUN: add_a_out, add_b_out and add_c_out are driven 0 so the adder inputs never toggle when idle.
- Arithmetic: unsigned modulo 2^W for sum_out; carries propagate strictly from the adder outputs. The block contains no internal adder.
- Index counter: $clog2(NUM_WORDS) bits; wrap-around is never reached because the exit condition is idx==NUM_WORDS-1.
- Input stability: operands are sampled only at accept, so changes on a_in, b_in or c_in after accept have no effect.

Decomposition:
- Shared package add_seq_pkg:
  - state enum (IDLE, RUN, DONE).
  - default WORD_W and NUM_WORDS constants.
  - function returning the index width.
- Sub-modules: none inside the block. The adder stays external and is connected by the parent.
- Test harness: instantiates multiword_add_seq together with CLA_16.

Test Plan (WORD_W=16, NUM_WORDS=4, W=64):
1. Reset: assert rst_n_in low, then release -> in_ready_out=1, out_valid_out=0, sum_out=0, c_out=0, ovf_out=0, add_*_out=0.
2. Carry across a word boundary: a=0x0000_0000_0000_FFFF, b=0x1, c=0 accepted at edge T -> out_valid_out rises at T+4; sum=0x0000_0000_0001_0000, c_out=0, ovf_out=0.
3. Full carry ripple: a=0xFFFF_FFFF_FFFF_FFFF, b=0, c=1 -> sum=0, c_out=1, ovf_out=0.
4. Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=0x1, c=0 -> sum=0x8000_0000_0000_0000, c_out=0, ovf_out=1.
5. Backpressure: hold out_ready_in=0 for 10 cycles after result 2, and pulse in_valid_in with new operands -> outputs stay stable, in_ready_out=0, new bundle not taken. After out_ready_in=1 for one cycle -> IDLE, in_ready_out=1.
6. Reset mid-operation: pull rst_n_in low after 2 words of a=b=0xFFFF_FFFF_FFFF_FFFF -> immediate IDLE, sum_out=0, out_valid_out never asserts. A following operation 5+7 -> sum=12.

Source files
------------

// File: rtl/add_seq_pkg.sv
// Shared types and defaults for the multi-word add sequencer.
package add_seq_pkg;

    localparam int unsigned WORD_W_DEF    = 16;
    localparam int unsigned NUM_WORDS_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Word index width; never below one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/multiword_add_seq.sv
// Sequences a wide add through an external WORD_W-bit adder slice, LSW first,
// chaining the carry between words and returning sum, carry-out and overflow.
module multiword_add_seq
    import add_seq_pkg::*;
#(
    parameter int unsigned WORD_W    = WORD_W_DEF,
    parameter int unsigned NUM_WORDS = NUM_WORDS_DEF
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        in_valid_in,
    output logic                        in_ready_out,
    input  logic [WORD_W*NUM_WORDS-1:0] a_in,
    input  logic [WORD_W*NUM_WORDS-1:0] b_in,
    input  logic                        c_in,
    output logic                        out_valid_out,
    input  logic                        out_ready_in,
    output logic [WORD_W*NUM_WORDS-1:0] sum_out,
    output logic                        c_out,
    output logic                        ovf_out,
    output logic [WORD_W-1:0]           add_a_out,
    output logic [WORD_W-1:0]           add_b_out,
    output logic                        add_c_out,
    input  logic [WORD_W-1:0]           add_s_in,
    input  logic                        add_c_in
);

    localparam int unsigned IDX_W = idx_width(NUM_WORDS);

    state_e state_q, state_d;

    logic [NUM_WORDS-1:0][WORD_W-1:0] a_q, b_q, sum_q;
    logic                             carry_q;
    logic [IDX_W-1:0]                 idx_q;
    logic                             c_q, ovf_q;
    logic                             accept;
    logic                             last_word;

    assign accept    = in_valid_in & in_ready_out;
    assign last_word = (idx_q == IDX_W'(NUM_WORDS - 1));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (last_word) state_d = DONE;
            DONE:    if (out_ready_in) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake and adder drive decode; adder inputs held at zero outside RUN.
    always_comb begin
        in_ready_out  = 1'b0;
        out_valid_out = 1'b0;
        add_a_out     = '0;
        add_b_out     = '0;
        add_c_out     = 1'b0;
        case (state_q)
            IDLE: in_ready_out = 1'b1;
            RUN: begin
                add_a_out = a_q[idx_q];
                add_b_out = b_q[idx_q];
                add_c_out = carry_q;
            end
            DONE:    out_valid_out = 1'b1;
            default: in_ready_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= a_in;
                        b_q     <= b_in;
                        carry_q <= c_in;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    sum_q[idx_q] <= add_s_in;
                    carry_q      <= add_c_in;
                    idx_q        <= idx_q + IDX_W'(1);
                    // Overflow: operands agree in sign but the top slice result does not.
                    if (last_word) begin
                        c_q   <= add_c_in;
                        ovf_q <= (a_q[NUM_WORDS-1][WORD_W-1] == b_q[NUM_WORDS-1][WORD_W-1]) &
                                 (add_s_in[WORD_W-1] != a_q[NUM_WORDS-1][WORD_W-1]);
                    end
                end
                default: ;
            endcase
        end
    end

    assign sum_out = sum_q;
    assign c_out   = c_q;
    assign ovf_out = ovf_q;

endmodule
